// File: rtl/inst_encoder.sv
// Instruction encoder: packs decoded fields into 32-bit words, tags each
// with a byte address and queues it in a 2-entry FIFO for IMEM writes.
//  in_*  : field bundle (valid/ready), addr_load/addr_val : counter load
//  out_* : FIFO head (valid/ready), err_illegal, err_range, word_count
module inst_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [3:0]  in_func,
   input  logic [3:0]  in_rd,
   input  logic [3:0]  in_rs1,
   input  logic [3:0]  in_rs2,
   input  logic [31:0] in_imm,
   input  logic        addr_load,
   input  logic [31:0] addr_val,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_addr,
   output logic [31:0] out_word,
   output logic        err_illegal,
   output logic        err_range,
   output logic [15:0] word_count
);

   localparam logic [3:0] OP_ALUR   = 4'h0;
   localparam logic [3:0] OP_CMPR   = 4'h2;
   localparam logic [3:0] OP_SW     = 4'h5;
   localparam logic [3:0] OP_BRANCH = 4'h6;
   localparam logic [3:0] OP_ALUI   = 4'h8;
   localparam logic [3:0] OP_LW     = 4'h9;
   localparam logic [3:0] OP_CMPI   = 4'hA;
   localparam logic [3:0] OP_JAL    = 4'hB;

   logic [1:0]  occ_q, occ_d, occ_mid;
   logic [63:0] ent0_q, ent0_d;
   logic [63:0] ent1_q, ent1_d;
   logic [31:0] addr_q, addr_d, cur_addr;
   logic        err_illegal_q, err_illegal_d;
   logic        err_range_q, err_range_d;
   logic [15:0] cnt_q, cnt_d;

   logic [31:0] enc_word;
   logic        legal, imm_fmt, imm_bad;
   logic        accept, push, pop;

   always_comb begin
      enc_word = '0;
      legal    = 1'b1;
      imm_fmt  = 1'b0;
      case (in_op)
         OP_ALUR, OP_CMPR:
            enc_word = {in_rd, in_rs1, in_rs2, 12'h000, in_func, in_op};
         OP_ALUI, OP_LW, OP_CMPI, OP_JAL: begin
            enc_word = {in_rd, in_rs1, in_imm[15:0], in_func, in_op};
            imm_fmt  = 1'b1;
         end
         OP_SW, OP_BRANCH: begin
            enc_word = {in_rs1, in_rs2, in_imm[15:0], in_func, in_op};
            imm_fmt  = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // Fits in 16-bit signed only when bits 31:15 are a pure sign extension.
   assign imm_bad = (|in_imm[31:15]) & ~(&in_imm[31:15]);

   assign in_ready  = (occ_q != 2'd2);
   assign out_valid = (occ_q != 2'd0);
   assign accept    = in_valid & in_ready;
   assign push      = accept & legal;
   assign pop       = out_valid & out_ready;

   // A same-cycle load wins over the stored counter for the word it tags.
   assign cur_addr = addr_load ? addr_val : addr_q;

   always_comb begin
      addr_d        = cur_addr;
      cnt_d         = cnt_q;
      err_illegal_d = accept & ~legal;
      err_range_d   = err_range_q | (push & imm_fmt & imm_bad);
      if (push) begin
         addr_d = cur_addr + 32'(ADDR_STEP);
         cnt_d  = cnt_q + 16'd1;
      end
   end

   // Pop shifts entry 1 forward; the new word lands in the first free slot.
   always_comb begin
      occ_mid = occ_q - {1'b0, pop};
      ent0_d  = pop ? ent1_q : ent0_q;
      ent1_d  = ent1_q;
      if (push) begin
         if (occ_mid == 2'd0) ent0_d = {cur_addr, enc_word};
         else                 ent1_d = {cur_addr, enc_word};
      end
      occ_d = occ_mid + {1'b0, push};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q         <= 2'd0;
         ent0_q        <= '0;
         ent1_q        <= '0;
         addr_q        <= BASE_ADDR;
         err_illegal_q <= 1'b0;
         err_range_q   <= 1'b0;
         cnt_q         <= '0;
      end else begin
         occ_q         <= occ_d;
         ent0_q        <= ent0_d;
         ent1_q        <= ent1_d;
         addr_q        <= addr_d;
         err_illegal_q <= err_illegal_d;
         err_range_q   <= err_range_d;
         cnt_q         <= cnt_d;
      end
   end

   assign out_addr    = ent0_q[63:32];
   assign out_word    = ent0_q[31:0];
   assign err_illegal = err_illegal_q;
   assign err_range   = err_range_q;
   assign word_count  = cnt_q;

endmodule
